// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared definitions for the UART command-frame controller: FSM states,
// command codes and the default frame start marker.
package uart_cmd_ctrl_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_ARG  = 2'd2,
    ST_CHK  = 2'd3
  } state_e;

  localparam logic [BYTE_W-1:0] CMD_SET           = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_TOGGLE        = 8'h02;
  localparam logic [BYTE_W-1:0] CMD_CLEAR         = 8'h03;
  localparam logic [BYTE_W-1:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Saturating 8-bit increment for the error counter.
  function automatic logic [BYTE_W-1:0] sat_inc(input logic [BYTE_W-1:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rx_timeout_timer.sv
// Inter-byte idle timer: counts enabled cycles since the last clear and
// flags the cycle in which the count reaches CYCLES-1.
module rx_timeout_timer #(
  parameter int unsigned CYCLES = 50
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire_c
);

  localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear)       cnt_d = '0;
    else if (i_enable) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_expire_c = i_enable && (cnt_q == CNT_W'(CYCLES - 1));

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses SYNC/CMD/ARG/CHK frames from the UART byte stream and executes
// LED commands; flags bad checksums, unknown commands and idle timeouts.
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 12_000_000,
  parameter int unsigned TIMEOUT_CYCLES = CLK_HZ / 100,
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int unsigned NUM_LEDS       = 5
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_rx_valid,
  input  logic [7:0]          i_rx_data,
  output logic [NUM_LEDS-1:0] o_leds,
  output logic                o_frame_ok,
  output logic                o_frame_err,
  output logic                o_busy,
  output logic [7:0]          o_err_cnt
);

  state_e              state_q, state_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [7:0]          arg_q, arg_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;
  logic                ok_q, ok_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic                expire_c;

  rx_timeout_timer #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (i_rx_valid || (state_q == ST_IDLE)),
    .i_enable  (state_q != ST_IDLE),
    .o_expire_c(expire_c)
  );

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    arg_d   = arg_q;
    leds_d  = leds_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: if (i_rx_valid && (i_rx_data == SYNC_BYTE)) state_d = ST_CMD;
      ST_CMD: if (i_rx_valid) begin
        cmd_d   = i_rx_data;
        state_d = ST_ARG;
      end
      ST_ARG: if (i_rx_valid) begin
        arg_d   = i_rx_data;
        state_d = ST_CHK;
      end
      ST_CHK: if (i_rx_valid) begin
        state_d = ST_IDLE;
        if (i_rx_data != (cmd_q ^ arg_q)) begin
          err_d = 1'b1;
        end else begin
          case (cmd_q)
            CMD_SET:    begin leds_d = arg_q[NUM_LEDS-1:0];          ok_d = 1'b1; end
            CMD_TOGGLE: begin leds_d = leds_q ^ arg_q[NUM_LEDS-1:0]; ok_d = 1'b1; end
            CMD_CLEAR:  begin leds_d = '0;                           ok_d = 1'b1; end
            default:    err_d = 1'b1;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A byte arriving in the expiry cycle takes priority over the timeout.
    if (!i_rx_valid && expire_c) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end
    busy_d    = (state_d != ST_IDLE);
    err_cnt_d = err_d ? sat_inc(err_cnt_q) : err_cnt_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      arg_q     <= '0;
      leds_q    <= '0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      arg_q     <= arg_d;
      leds_q    <= leds_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_leds      = leds_q;
  assign o_frame_ok  = ok_q;
  assign o_frame_err = err_q;
  assign o_busy      = busy_q;
  assign o_err_cnt   = err_cnt_q;

endmodule
